// File: rtl/player_action_state_pkg.sv
// Shared types and helpers for the per-player action state block:
// action state encoding, comboMove codes and 8-bit saturating arithmetic.
package player_action_state_pkg;

    typedef enum logic [2:0] {
        GROUND = 3'd0,
        CROUCH = 3'd1,
        ATTACK = 3'd2,
        STUN   = 3'd3,
        KO     = 3'd4
    } actionStateT;

    localparam logic [1:0] COMBO_NONE    = 2'd0;
    localparam logic [1:0] COMBO_NORMAL  = 2'd1;
    localparam logic [1:0] COMBO_SPECIAL = 2'd2;
    localparam logic [1:0] COMBO_SUPER   = 2'd3;

    function automatic logic [7:0] sat8Add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    function automatic logic [7:0] sat8Sub(input logic [7:0] a, input logic [7:0] b);
        return (b >= a) ? 8'd0 : (a - b);
    endfunction

endpackage

// File: rtl/player_action_state_jump_physics.sv
// Vertical motion: integrates posY/velY once per step, clamping to the floor on landing.
// A launch loads the take-off velocity; position starts rising on the following step.
module player_action_state_jump_physics #(
    parameter int JUMP_V0 = 6,
    parameter int GRAVITY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    input  logic       launch,
    output logic [5:0] posY,
    output logic       airborne
);

    logic [4:0]        velY;
    logic signed [6:0] nextY;

    assign nextY    = signed'({1'b0, posY}) + signed'({{2{velY[4]}}, velY});
    assign airborne = (posY != 6'd0) || (velY != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            posY <= 6'd0;
            velY <= 5'd0;
        end else if (step) begin
            if (launch) begin
                velY <= 5'(JUMP_V0);
            end else if (airborne) begin
                // Touching or passing the floor ends the jump outright.
                if (nextY <= 7'sd0) begin
                    posY <= 6'd0;
                    velY <= 5'd0;
                end else begin
                    posY <= nextY[5:0];
                    velY <= velY - 5'(GRAVITY);
                end
            end
        end
    end

endmodule

// File: rtl/player_action_state.sv
// Per-player game state: position, jump, crouch/attack/stun timers and health.
// All state advances on gameTicks; hits arriving between ticks are coalesced.
module player_action_state
    import player_action_state_pkg::*;
#(
    parameter int X_MIN        = 0,
    parameter int X_MAX        = 80,
    parameter int X_START      = 8,
    parameter int WALK_STEP    = 1,
    parameter int JUMP_V0      = 6,
    parameter int GRAVITY      = 1,
    parameter int CROUCH_TICKS = 4,
    parameter int ATK1         = 3,
    parameter int ATK2         = 6,
    parameter int ATK3         = 10,
    parameter int STUN_TICKS   = 8,
    parameter int HEALTH_MAX   = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       gameTicks,
    input  logic       movingLeft,
    input  logic       movingRight,
    input  logic       isCrouching,
    input  logic       isJumping,
    input  logic       isBlocking,
    input  logic [1:0] comboMove,
    input  logic       hitReceived,
    input  logic [7:0] hitDamage,
    output logic [6:0] posX,
    output logic [5:0] posY,
    output logic       isCrouched,
    output logic       isInAir,
    output logic       isStunned,
    output logic       isPerformingAttackAnimation,
    output logic [1:0] attackType,
    output logic [7:0] health,
    output logic       isKO
);

    actionStateT state, stateNext;
    logic [3:0]  atkCnt, atkCntNext;
    logic [3:0]  stunCnt, stunCntNext;
    logic [3:0]  crCnt, crCntNext;
    logic [6:0]  posXNext;
    logic [7:0]  healthNext;
    logic [1:0]  attackTypeNext;
    logic        pendHit;
    logic [7:0]  pendDmg;
    logic        effHit;
    logic [7:0]  effDmg;
    logic        blocked;
    logic        launch;
    logic        physStep;
    logic [3:0]  atkLen;
    int          walkX;

    player_action_state_jump_physics #(
        .JUMP_V0 (JUMP_V0),
        .GRAVITY (GRAVITY)
    ) jumpPhysics (
        .clk      (clk),
        .rst_n    (rst_n),
        .step     (physStep),
        .launch   (launch),
        .posY     (posY),
        .airborne (isInAir)
    );

    assign physStep = gameTicks && (state != KO);

    // A hit arriving on the tick cycle itself joins the pending total.
    assign effHit  = pendHit || hitReceived;
    assign effDmg  = hitReceived ? sat8Add(pendDmg, hitDamage) : pendDmg;
    assign blocked = isBlocking && ((state == GROUND) || (state == CROUCH)) && !isInAir;

    always_comb begin
        case (comboMove)
            COMBO_NORMAL:  atkLen = 4'(ATK1);
            COMBO_SPECIAL: atkLen = 4'(ATK2);
            COMBO_SUPER:   atkLen = 4'(ATK3);
            default:       atkLen = 4'd0;
        endcase
    end

    always_comb begin
        walkX = int'(posX);
        if (movingRight && !movingLeft) begin
            walkX = walkX + WALK_STEP;
        end else if (movingLeft && !movingRight) begin
            walkX = walkX - WALK_STEP;
        end
        if (walkX > X_MAX) begin
            walkX = X_MAX;
        end else if (walkX < X_MIN) begin
            walkX = X_MIN;
        end
    end

    always_comb begin
        stateNext      = state;
        atkCntNext     = atkCnt;
        stunCntNext    = stunCnt;
        crCntNext      = crCnt;
        healthNext     = health;
        attackTypeNext = attackType;
        posXNext       = posX;
        launch         = 1'b0;

        if (gameTicks && (state != KO)) begin
            if (state == GROUND) begin
                posXNext = 7'(walkX);
            end

            if (effHit && !blocked) begin
                healthNext     = sat8Sub(health, effDmg);
                attackTypeNext = COMBO_NONE;
                if (healthNext == 8'd0) begin
                    stateNext = KO;
                end else begin
                    stateNext   = STUN;
                    stunCntNext = 4'(STUN_TICKS);
                end
            end else begin
                if (effHit) begin
                    healthNext = sat8Sub(health, effDmg >> 2);
                end
                if (effHit && (healthNext == 8'd0)) begin
                    stateNext      = KO;
                    attackTypeNext = COMBO_NONE;
                end else begin
                    // A blocked hit takes the tick: no new action starts, timers still run.
                    case (state)
                        GROUND: begin
                            if (!effHit && (comboMove != COMBO_NONE)) begin
                                stateNext      = ATTACK;
                                atkCntNext     = atkLen;
                                attackTypeNext = comboMove;
                            end else if (!effHit && isCrouching && !isInAir) begin
                                stateNext = CROUCH;
                                crCntNext = 4'(CROUCH_TICKS);
                            end else if (!effHit && isJumping && !isInAir) begin
                                launch = 1'b1;
                            end
                        end
                        CROUCH: begin
                            if (!effHit && (comboMove != COMBO_NONE)) begin
                                stateNext      = ATTACK;
                                atkCntNext     = atkLen;
                                attackTypeNext = comboMove;
                            end else if (crCnt == 4'd1) begin
                                if (isCrouching) begin
                                    crCntNext = 4'(CROUCH_TICKS);
                                end else begin
                                    stateNext = GROUND;
                                    crCntNext = 4'd0;
                                end
                            end else begin
                                crCntNext = crCnt - 4'd1;
                            end
                        end
                        ATTACK: begin
                            atkCntNext = atkCnt - 4'd1;
                            if (atkCnt == 4'd1) begin
                                stateNext      = GROUND;
                                attackTypeNext = COMBO_NONE;
                            end
                        end
                        STUN: begin
                            stunCntNext = stunCnt - 4'd1;
                            if (stunCnt == 4'd1) begin
                                stateNext = GROUND;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= GROUND;
            atkCnt     <= 4'd0;
            stunCnt    <= 4'd0;
            crCnt      <= 4'd0;
            posX       <= 7'(X_START);
            health     <= 8'(HEALTH_MAX);
            attackType <= COMBO_NONE;
            pendHit    <= 1'b0;
            pendDmg    <= 8'd0;
        end else begin
            state      <= stateNext;
            atkCnt     <= atkCntNext;
            stunCnt    <= stunCntNext;
            crCnt      <= crCntNext;
            posX       <= posXNext;
            health     <= healthNext;
            attackType <= attackTypeNext;
            if (gameTicks) begin
                pendHit <= 1'b0;
                pendDmg <= 8'd0;
            end else if (hitReceived) begin
                pendHit <= 1'b1;
                pendDmg <= sat8Add(pendDmg, hitDamage);
            end
        end
    end

    assign isCrouched                  = (state == CROUCH);
    assign isStunned                   = (state == STUN) || (state == KO);
    assign isPerformingAttackAnimation = (state == ATTACK);
    assign isKO                        = (state == KO);

endmodule

// File: tb/tb_player_action_state.sv
// Directed scenarios plus randomized traffic against a tick-level behavioural model.
module tb_player_action_state;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       gameTicks = 1'b0;
    logic       movingLeft = 1'b0;
    logic       movingRight = 1'b0;
    logic       isCrouching = 1'b0;
    logic       isJumping = 1'b0;
    logic       isBlocking = 1'b0;
    logic [1:0] comboMove = 2'd0;
    logic       hitReceived = 1'b0;
    logic [7:0] hitDamage = 8'd0;
    logic [6:0] posX;
    logic [5:0] posY;
    logic       isCrouched, isInAir, isStunned, isPerformingAttackAnimation, isKO;
    logic [1:0] attackType;
    logic [7:0] health;

    int errors = 0;
    int checks = 0;

    // Behavioural model: remaining ticks per activity, zero meaning inactive.
    int mX, mY, mV, mHp, mAtk, mStun, mCr, mAType, mPendDmg;
    bit mKo, mPend;

    always #5 clk = ~clk;

    player_action_state dut (
        .clk                         (clk),
        .rst_n                       (rst_n),
        .gameTicks                   (gameTicks),
        .movingLeft                  (movingLeft),
        .movingRight                 (movingRight),
        .isCrouching                 (isCrouching),
        .isJumping                   (isJumping),
        .isBlocking                  (isBlocking),
        .comboMove                   (comboMove),
        .hitReceived                 (hitReceived),
        .hitDamage                   (hitDamage),
        .posX                        (posX),
        .posY                        (posY),
        .isCrouched                  (isCrouched),
        .isInAir                     (isInAir),
        .isStunned                   (isStunned),
        .isPerformingAttackAnimation (isPerformingAttackAnimation),
        .attackType                  (attackType),
        .health                      (health),
        .isKO                        (isKO)
    );

    task automatic modelReset();
        mX = 8; mY = 0; mV = 0; mHp = 255; mAtk = 0; mStun = 0; mCr = 0;
        mAType = 0; mKo = 0; mPend = 0; mPendDmg = 0;
    endtask

    task automatic modelTick();
        int dmg, n;
        bit hit, inAir, wasGround, canBlock, launchNow;
        int atkLen[4];
        atkLen = '{0, 3, 6, 10};
        hit = mPend || hitReceived;
        dmg = mPendDmg + (hitReceived ? int'(hitDamage) : 0);
        if (dmg > 255) dmg = 255;
        mPend = 0;
        mPendDmg = 0;
        if (mKo) return;
        inAir = (mY != 0) || (mV != 0);
        wasGround = (mAtk == 0) && (mStun == 0) && (mCr == 0);
        canBlock = isBlocking && (mAtk == 0) && (mStun == 0) && !inAir;
        launchNow = 0;
        if (hit && !canBlock) begin
            mHp = (mHp > dmg) ? mHp - dmg : 0;
            mAtk = 0; mCr = 0; mAType = 0;
            if (mHp == 0) begin mKo = 1; mStun = 0; end
            else mStun = 8;
        end else begin
            if (hit) mHp = (mHp > dmg / 4) ? mHp - dmg / 4 : 0;
            if (hit && mHp == 0) begin
                mKo = 1; mCr = 0;
            end else if (mAtk > 0) begin
                mAtk--;
                if (mAtk == 0) mAType = 0;
            end else if (mStun > 0) begin
                mStun--;
            end else if (!hit && comboMove != 0) begin
                mAtk = atkLen[comboMove]; mAType = int'(comboMove); mCr = 0;
            end else if (mCr > 0) begin
                mCr--;
                if (mCr == 0 && isCrouching) mCr = 4;
            end else if (!hit && isCrouching && !inAir) begin
                mCr = 4;
            end else if (!hit && isJumping && !inAir) begin
                launchNow = 1;
            end
        end
        if (wasGround) begin
            if (movingRight && !movingLeft) mX = (mX + 1 > 80) ? 80 : mX + 1;
            else if (movingLeft && !movingRight) mX = (mX - 1 < 0) ? 0 : mX - 1;
        end
        if (launchNow) begin
            mV = 6;
        end else if (inAir) begin
            n = mY + mV;
            if (n <= 0) begin mY = 0; mV = 0; end
            else begin mY = n; mV--; end
        end
    endtask

    // One clock: the model consumes the inputs presented for this edge, outputs sampled 1ns after.
    task automatic step();
        if (gameTicks) begin
            modelTick();
        end else if (hitReceived) begin
            mPend = 1;
            mPendDmg = (mPendDmg + int'(hitDamage) > 255) ? 255 : mPendDmg + int'(hitDamage);
        end
        @(posedge clk);
        #1;
        gameTicks = 1'b0;
        hitReceived = 1'b0;
    endtask

    task automatic tick();
        gameTicks = 1'b1;
        step();
    endtask

    task automatic hitPulse(input int d);
        hitReceived = 1'b1;
        hitDamage = 8'(d);
        step();
    endtask

    task automatic clearInputs();
        movingLeft = 0; movingRight = 0; isCrouching = 0; isJumping = 0;
        isBlocking = 0; comboMove = 2'd0; hitReceived = 0; gameTicks = 0;
    endtask

    task automatic applyReset();
        clearInputs();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        modelReset();
    endtask

    task automatic test_reset();
        checks += 4;
        if (posX !== 7'd8) begin errors++; $display("FAIL reset_posX got %0d expected 8", posX); end
        if (health !== 8'd255) begin errors++; $display("FAIL reset_health got %0d expected 255", health); end
        if ({posY, isInAir, isCrouched, isStunned, isKO} !== 10'd0) begin
            errors++; $display("FAIL reset_flags got posY=%0d air=%b cr=%b st=%b ko=%b expected all 0",
                               posY, isInAir, isCrouched, isStunned, isKO);
        end
        if ({isPerformingAttackAnimation, attackType} !== 3'd0) begin
            errors++; $display("FAIL reset_attack got %b/%0d expected 0/0", isPerformingAttackAnimation, attackType);
        end
        rst_n = 1'b1;
        modelReset();
        $display("test_reset: posX=%0d health=%0d", posX, health);
    endtask

    task automatic test_walk();
        applyReset();
        movingRight = 1;
        repeat (5) tick();
        checks++;
        if (posX !== 7'd13) begin errors++; $display("FAIL walk_5 got %0d expected 13", posX); end
        repeat (70) tick();
        checks++;
        if (posX !== 7'd80) begin errors++; $display("FAIL walk_clamp got %0d expected 80", posX); end
        movingLeft = 1;
        tick();
        checks++;
        if (posX !== 7'd80) begin errors++; $display("FAIL walk_both got %0d expected 80", posX); end
        movingRight = 0;
        tick();
        checks++;
        if (posX !== 7'd79) begin errors++; $display("FAIL walk_left got %0d expected 79", posX); end
        clearInputs();
        $display("test_walk: posX=%0d", posX);
    endtask

    task automatic test_jump();
        int expY[13];
        expY = '{6, 11, 15, 18, 20, 21, 21, 20, 18, 15, 11, 6, 0};
        applyReset();
        isJumping = 1;
        tick();
        isJumping = 0;
        checks++;
        if (posY !== 6'd0 || isInAir !== 1'b1) begin
            errors++; $display("FAIL jump_launch got posY=%0d air=%b expected 0/1", posY, isInAir);
        end
        for (int i = 0; i < 13; i++) begin
            tick();
            checks++;
            if (posY !== 6'(expY[i]) || isInAir !== (expY[i] != 0)) begin
                errors++; $display("FAIL jump_step%0d got posY=%0d air=%b expected %0d/%b",
                                   i, posY, isInAir, expY[i], expY[i] != 0);
            end
            if (i == 0) begin
                step();
                checks++;
                if (posY !== 6'd6) begin errors++; $display("FAIL jump_hold got %0d expected 6", posY); end
            end
        end
        $display("test_jump: landed posY=%0d", posY);
    endtask

    task automatic test_attack();
        applyReset();
        comboMove = 2'd2;
        tick();
        comboMove = 2'd0;
        for (int k = 1; k <= 7; k++) begin
            checks++;
            if (isPerformingAttackAnimation !== (k <= 6) || attackType !== ((k <= 6) ? 2'd2 : 2'd0)) begin
                errors++; $display("FAIL attack_tick%0d got anim=%b type=%0d expected %b/%0d",
                                   k, isPerformingAttackAnimation, attackType, k <= 6, (k <= 6) ? 2 : 0);
            end
            if (k < 7) tick();
        end
        $display("test_attack: anim=%b type=%0d", isPerformingAttackAnimation, attackType);
    endtask

    task automatic test_hit_stun();
        applyReset();
        comboMove = 2'd3;
        tick();
        comboMove = 2'd0;
        tick();
        tick();
        hitPulse(40);
        tick();
        checks += 2;
        if (health !== 8'd215) begin errors++; $display("FAIL stun_health got %0d expected 215", health); end
        if (isStunned !== 1'b1 || isPerformingAttackAnimation !== 1'b0 || attackType !== 2'd0) begin
            errors++; $display("FAIL stun_abort got st=%b anim=%b type=%0d expected 1/0/0",
                               isStunned, isPerformingAttackAnimation, attackType);
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (isStunned !== (k < 8)) begin
                errors++; $display("FAIL stun_tick%0d got %b expected %b", k, isStunned, k < 8);
            end
        end
        $display("test_hit_stun: health=%0d stunned=%b", health, isStunned);
    endtask

    task automatic test_block_ko();
        applyReset();
        isBlocking = 1;
        hitPulse(40);
        tick();
        checks++;
        if (health !== 8'd245 || isStunned !== 1'b0) begin
            errors++; $display("FAIL block_hit got health=%0d st=%b expected 245/0", health, isStunned);
        end
        isBlocking = 0;
        hitPulse(200);
        hitPulse(100);
        checks++;
        if (health !== 8'd245) begin errors++; $display("FAIL block_pending got %0d expected 245", health); end
        tick();
        checks++;
        if (health !== 8'd0 || isKO !== 1'b1 || isStunned !== 1'b1) begin
            errors++; $display("FAIL ko_enter got health=%0d ko=%b st=%b expected 0/1/1", health, isKO, isStunned);
        end
        movingRight = 1; isJumping = 1; comboMove = 2'd1;
        repeat (4) begin
            hitPulse(10);
            tick();
        end
        checks++;
        if (health !== 8'd0 || isKO !== 1'b1 || posX !== 7'd8 || posY !== 6'd0 ||
            isInAir !== 1'b0 || isPerformingAttackAnimation !== 1'b0) begin
            errors++; $display("FAIL ko_hold got health=%0d ko=%b posX=%0d posY=%0d air=%b anim=%b expected 0/1/8/0/0/0",
                               health, isKO, posX, posY, isInAir, isPerformingAttackAnimation);
        end
        clearInputs();
        $display("test_block_ko: health=%0d ko=%b", health, isKO);
    endtask

    task automatic test_async_reset();
        applyReset();
        isJumping = 1;
        tick();
        isJumping = 0;
        tick();
        tick();
        hitPulse(50);
        tick();
        checks++;
        if (posY !== 6'd15 || health !== 8'd205) begin
            errors++; $display("FAIL areset_pre got posY=%0d health=%0d expected 15/205", posY, health);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (posY !== 6'd0 || isInAir !== 1'b0 || health !== 8'd255 || isStunned !== 1'b0) begin
            errors++; $display("FAIL areset_async got posY=%0d air=%b health=%0d st=%b expected 0/0/255/0",
                               posY, isInAir, health, isStunned);
        end
        rst_n = 1'b1;
        modelReset();
        $display("test_async_reset: posY=%0d health=%0d", posY, health);
    endtask

    task automatic test_random();
        int bad;
        applyReset();
        bad = 0;
        for (int i = 0; i < 1500; i++) begin
            if (i % 300 == 299) applyReset();
            movingLeft  = ($urandom_range(0, 2) == 0);
            movingRight = ($urandom_range(0, 1) == 0);
            isCrouching = ($urandom_range(0, 5) == 0);
            isJumping   = ($urandom_range(0, 4) == 0);
            isBlocking  = ($urandom_range(0, 1) == 0);
            comboMove   = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            gameTicks   = ($urandom_range(0, 2) == 0);
            hitReceived = ($urandom_range(0, 24) == 0);
            hitDamage   = 8'($urandom_range(0, 40));
            step();
            checks += 5;
            if (posX !== 7'(mX) || posY !== 6'(mY)) begin
                bad++; errors++; $display("FAIL rnd_pos cyc %0d got %0d,%0d expected %0d,%0d", i, posX, posY, mX, mY);
            end
            if (isInAir !== ((mY != 0) || (mV != 0)) || isCrouched !== (mCr > 0)) begin
                bad++; errors++; $display("FAIL rnd_air_crouch cyc %0d got %b,%b expected %b,%b",
                                          i, isInAir, isCrouched, (mY != 0) || (mV != 0), mCr > 0);
            end
            if (isStunned !== (mKo || mStun > 0) || isKO !== mKo) begin
                bad++; errors++; $display("FAIL rnd_stun_ko cyc %0d got %b,%b expected %b,%b",
                                          i, isStunned, isKO, mKo || mStun > 0, mKo);
            end
            if (isPerformingAttackAnimation !== (mAtk > 0) || attackType !== 2'(mAType)) begin
                bad++; errors++; $display("FAIL rnd_attack cyc %0d got %b,%0d expected %b,%0d",
                                          i, isPerformingAttackAnimation, attackType, mAtk > 0, mAType);
            end
            if (health !== 8'(mHp)) begin
                bad++; errors++; $display("FAIL rnd_health cyc %0d got %0d expected %0d", i, health, mHp);
            end
        end
        clearInputs();
        $display("test_random: 1500 cycles, %0d mismatching cycles", bad);
    endtask

    initial begin
        modelReset();
        #7;
        test_reset();
        test_walk();
        test_jump();
        test_attack();
        test_hit_stun();
        test_block_ko();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
